// File: rtl/vinsn_dispatch_queue_if.sv
// Request types and helper decoders shared by the dispatch queue and its neighbours,
// plus the handshake bundle between decoder, VFUs and operand requester.
package vinsn_dispatch_pkg;
  localparam int unsigned NrVFU = 4;

  typedef struct packed {
    logic [3:0]  vop;
    logic [1:0]  vew;
    logic [7:0]  vlB;
    logic [1:0]  use_vs;
    logic [15:0] scalar_op;
    logic [3:0]  insn_id;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
  } issue_req_t;

  typedef struct packed {
    logic [3:0]  vop;
    logic [1:0]  vew;
    logic [7:0]  vlB;
    logic [1:0]  use_vs;
    logic [15:0] scalar_op;
    logic [3:0]  insn_id;
    logic [7:0]  waddr;
  } vfu_req_t;

  typedef struct packed {
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [7:0] vlB;
    logic [2:0] queue_req;
  } op_req_t;

  // Opcode space is split in four contiguous groups: ALU, MFPU, load, store.
  function automatic logic [1:0] GetVFUByVOp(input logic [3:0] vop);
    return vop[3:2];
  endfunction

  function automatic logic [7:0] GetVRFAddr(input logic [4:0] vd);
    return {vd, 3'b000};
  endfunction

  // Bit 2 selects the store-data queue, bits 1:0 the vs2/vs1 read queues.
  function automatic logic [2:0] GetOpQueue(input logic [3:0] vop, input logic [1:0] use_vs);
    return {(vop[3:2] == 2'd3), use_vs};
  endfunction
endpackage

interface vinsn_dispatch_queue_if;
  import vinsn_dispatch_pkg::*;

  logic             issue_req_valid_i;
  logic             issue_req_ready_o;
  issue_req_t       issue_req_i;
  logic [NrVFU-1:0] vfu_req_valid_o;
  logic [NrVFU-1:0] vfu_req_ready_i;
  vfu_req_t         vfu_req_o;
  logic             op_req_valid_o;
  logic             op_req_ready_i;
  op_req_t          op_req_o;

  modport master (
    output issue_req_valid_i, issue_req_i, vfu_req_ready_i, op_req_ready_i,
    input  issue_req_ready_o, vfu_req_valid_o, vfu_req_o, op_req_valid_o, op_req_o
  );

  modport slave (
    input  issue_req_valid_i, issue_req_i, vfu_req_ready_i, op_req_ready_i,
    output issue_req_ready_o, vfu_req_valid_o, vfu_req_o, op_req_valid_o, op_req_o
  );
endinterface

// File: rtl/vinsn_dispatch_queue.sv
// Circular queue launching each decoded instruction once to its VFU and once to the operand
// requester; 1-cycle latency, intake independent of downstream ready. VINSN_DISPATCH_BYPASS_EN adds an empty-queue bypass.
module vinsn_dispatch_queue
  import vinsn_dispatch_pkg::*;
#(
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned CntW       = $clog2(QueueDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  vinsn_dispatch_queue_if.slave dq,
  input  logic                  flush_i,
  output logic [CntW-1:0]       occupancy_o
);
  localparam int unsigned PtrW = $clog2(QueueDepth);

  issue_req_t            mem_q [QueueDepth];
  issue_req_t            mem_d [QueueDepth];
  logic [QueueDepth-1:0] vfu_sent_q, vfu_sent_d;
  logic [QueueDepth-1:0] op_sent_q, op_sent_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  issue_req_t sel;
  logic       sel_vld, sel_vfu_sent, sel_op_sent;
  logic       queued, byp;
  logic [1:0] tgt;
  logic       vfu_vld, op_vld, vfu_hs, op_hs;
  logic       push, store, pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(QueueDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign dq.issue_req_ready_o = (count_q < CntW'(QueueDepth)) && !flush_i;

  always_comb begin
    queued       = (count_q != '0);
    sel          = mem_q[rd_ptr_q];
    sel_vld      = queued;
    sel_vfu_sent = vfu_sent_q[rd_ptr_q];
    sel_op_sent  = op_sent_q[rd_ptr_q];
    byp          = 1'b0;
`ifdef VINSN_DISPATCH_BYPASS_EN
    // Empty queue: present the incoming request directly, as if it were a fresh head.
    if (!queued && !flush_i && dq.issue_req_valid_i) begin
      byp          = 1'b1;
      sel          = dq.issue_req_i;
      sel_vld      = 1'b1;
      sel_vfu_sent = 1'b0;
      sel_op_sent  = 1'b0;
    end
`endif
    tgt     = GetVFUByVOp(sel.vop);
    vfu_vld = sel_vld && !sel_vfu_sent;
    op_vld  = sel_vld && !sel_op_sent;
    vfu_hs  = vfu_vld && dq.vfu_req_ready_i[tgt];
    op_hs   = op_vld && dq.op_req_ready_i;
    push    = dq.issue_req_valid_i && dq.issue_req_ready_o;
    store   = push && !(byp && vfu_hs && op_hs);
    pop     = queued && (sel_vfu_sent || vfu_hs) && (sel_op_sent || op_hs);
  end

  always_comb begin
    mem_d      = mem_q;
    vfu_sent_d = vfu_sent_q;
    op_sent_d  = op_sent_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush_i) begin
      vfu_sent_d = '0;
      op_sent_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (queued && vfu_hs) vfu_sent_d[rd_ptr_q] = 1'b1;
      if (queued && op_hs)  op_sent_d[rd_ptr_q]  = 1'b1;
      if (pop) begin
        vfu_sent_d[rd_ptr_q] = 1'b0;
        op_sent_d[rd_ptr_q]  = 1'b0;
        rd_ptr_d             = next_ptr(rd_ptr_q);
      end
      // Push and pop never share a slot: push needs a non-full queue, pop a non-empty one.
      if (store) begin
        mem_d[wr_ptr_q]      = dq.issue_req_i;
        vfu_sent_d[wr_ptr_q] = byp && vfu_hs;
        op_sent_d[wr_ptr_q]  = byp && op_hs;
        wr_ptr_d             = next_ptr(wr_ptr_q);
      end
      count_d = count_q + CntW'(store) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vfu_sent_q <= '0;
      op_sent_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      vfu_sent_q <= vfu_sent_d;
      op_sent_q  <= op_sent_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign dq.vfu_req_valid_o = vfu_vld ? (NrVFU'(1) << tgt) : '0;
  assign dq.op_req_valid_o  = op_vld;

  assign dq.vfu_req_o = '{vop:       sel.vop,
                          vew:       sel.vew,
                          vlB:       sel.vlB,
                          use_vs:    sel.use_vs,
                          scalar_op: sel.scalar_op,
                          insn_id:   sel.insn_id,
                          waddr:     GetVRFAddr(sel.vd)};

  assign dq.op_req_o = '{vs1:       sel.vs1,
                         vs2:       sel.vs2,
                         vlB:       sel.vlB,
                         queue_req: GetOpQueue(sel.vop, sel.use_vs)};

  assign occupancy_o = count_q;
endmodule
